// File: rtl/alu_if.sv
// alu_if: operand/control bundle into the ALU and its registered result/status back out.
interface alu_if;
  logic [2:0] alu_ctrl;
  logic [7:0] alu_AI;
  logic [7:0] alu_BI;
  logic       alu_carry;
  logic       alu_BCD;
  logic [7:0] alu_Y;
  logic [7:0] alu_flags;
  modport master (output alu_ctrl, alu_AI, alu_BI, alu_carry, alu_BCD, input alu_Y, alu_flags);
  modport slave (input alu_ctrl, alu_AI, alu_BI, alu_carry, alu_BCD, output alu_Y, alu_flags);
endinterface

// File: rtl/alu.sv
// alu: 8-bit 6502-style ALU, binary/decimal add and subtract, logic and shifts, one-cycle registered result and P-order flags.
module alu (
  input logic clk,
  input logic reset,
  alu_if.slave bus
);
  logic [7:0] a, b, y, dec_sum, dec_diff;
  logic [8:0] bsum, bdiff;
  logic [4:0] dlo, dhi;
  logic       lo_c, hi_c, lo_b, c, v, v_add, v_sub;
  assign a = bus.alu_AI;
  assign b = bus.alu_BI;
  assign bsum = {1'b0, a} + {1'b0, b} + {8'd0, bus.alu_carry};
  assign bdiff = {1'b0, a} + {1'b0, ~b} + {8'd0, bus.alu_carry};
  assign v_add = (a[7] == b[7]) && (bsum[7] != a[7]);
  assign v_sub = (a[7] != b[7]) && (bdiff[7] != a[7]);
  // Decimal add: nibble-wise with +6 correction; carry out of the low digit feeds the high digit.
  assign dlo = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, bus.alu_carry};
  assign lo_c = dlo > 5'd9;
  assign dhi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, lo_c};
  assign hi_c = dhi > 5'd9;
  assign dec_sum = {dhi[3:0] + (hi_c ? 4'd6 : 4'd0), dlo[3:0] + (lo_c ? 4'd6 : 4'd0)};
  // Decimal subtract: correct the binary difference per digit that borrowed.
  assign lo_b = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'd0, ~bus.alu_carry});
  assign dec_diff = bdiff[7:0] - (lo_b ? 8'h06 : 8'h00) - (bdiff[8] ? 8'h00 : 8'h60);
  always_comb begin
    y = a;
    c = 1'b0;
    v = 1'b0;
    case (bus.alu_ctrl)
      3'd0: begin
        y = bus.alu_BCD ? dec_sum : bsum[7:0];
        c = bus.alu_BCD ? hi_c : bsum[8];
        v = v_add;
      end
      3'd1: begin
        y = bus.alu_BCD ? dec_diff : bdiff[7:0];
        c = bdiff[8];
        v = v_sub;
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: begin
        y = {a[6:0], bus.alu_carry};
        c = a[7];
      end
      3'd6: begin
        y = {bus.alu_carry, a[7:1]};
        c = a[0];
      end
      default: y = a;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.alu_Y     <= 8'h00;
      bus.alu_flags <= 8'h20;
    end else begin
      bus.alu_Y     <= y;
      bus.alu_flags <= {y[7], v, 1'b1, 1'b0, bus.alu_BCD, 1'b0, y == 8'h00, c};
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: table vectors, randomized scoreboard stream and async-reset sequences for alu.
module tb_alu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  alu_if bus ();
  alu dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ctrl;
    logic [7:0] a, b;
    logic       c, d;
    logic [7:0] y, f;
  } vec_t;
  typedef struct packed {
    logic [7:0] y, f;
  } exp_t;
  exp_t q[$];
  vec_t tbl[16];

  task automatic check(input string name, input logic [7:0] y, input logic [7:0] f);
    checks++;
    if (bus.alu_Y !== y || bus.alu_flags !== f) begin
      failures++;
      $display("FAIL %s: got Y=%h flags=%h, want Y=%h flags=%h", name, bus.alu_Y, bus.alu_flags, y, f);
    end
  endtask

  task automatic step(input string name, input logic [2:0] ctrl, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic d, input logic [7:0] ey, input logic [7:0] ef);
    exp_t e;
    @(negedge clk);
    bus.alu_ctrl = ctrl; bus.alu_AI = a; bus.alu_BI = b; bus.alu_carry = c; bus.alu_BCD = d;
    q.push_back('{ey, ef});
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = q.pop_front();
      check(name, e.y, e.f);
    end
  endtask

  function automatic int to_dec(input logic [7:0] x);
    return int'(x[7:4]) * 10 + int'(x[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int x);
    return {4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic exp_t model(input logic [2:0] ctrl, input logic [7:0] a, input logic [7:0] b, input logic c, input logic d);
    int s;
    logic [7:0] y, yb;
    logic cf, vf;
    cf = 1'b0; vf = 1'b0; y = a;
    if (ctrl == 3'd0) begin
      s = int'(a) + int'(b) + int'(c);
      yb = s[7:0];
      vf = ((a ^ yb) & (b ^ yb) & 8'h80) != 0;
      if (d) begin
        s = to_dec(a) + to_dec(b) + int'(c);
        cf = s > 99; y = to_bcd(s % 100);
      end else begin
        cf = s > 255; y = yb;
      end
    end else if (ctrl == 3'd1) begin
      s = int'(a) - int'(b) - (c ? 0 : 1);
      yb = s[7:0];
      vf = ((a ^ b) & (a ^ yb) & 8'h80) != 0;
      cf = s >= 0;
      y = d ? to_bcd((to_dec(a) - to_dec(b) - (c ? 0 : 1) + 100) % 100) : yb;
    end else if (ctrl == 3'd2) y = a & b;
    else if (ctrl == 3'd3) y = a | b;
    else if (ctrl == 3'd4) y = a ^ b;
    else if (ctrl == 3'd5) begin y = (a << 1) | {7'd0, c}; cf = a[7]; end
    else if (ctrl == 3'd6) begin y = (a >> 1) | {c, 7'd0}; cf = a[0]; end
    return '{y, {y[7], vf, 2'b10, d, 1'b0, y == 8'h00, cf}};
  endfunction

  initial begin
    tbl[0]  = '{3'd0, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 8'hE0};
    tbl[1]  = '{3'd0, 8'h58, 8'h46, 1'b1, 1'b1, 8'h05, 8'h69};
    tbl[2]  = '{3'd1, 8'h46, 8'h12, 1'b1, 1'b1, 8'h34, 8'h29};
    tbl[3]  = '{3'd1, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 8'hA0};
    tbl[4]  = '{3'd5, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 8'h23};
    tbl[5]  = '{3'd6, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 8'hA1};
    tbl[6]  = '{3'd2, 8'hF0, 8'h3C, 1'b1, 1'b1, 8'h30, 8'h28};
    tbl[7]  = '{3'd3, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h22};
    tbl[8]  = '{3'd4, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 8'hA0};
    tbl[9]  = '{3'd7, 8'h7F, 8'hAA, 1'b1, 1'b0, 8'h7F, 8'h20};
    tbl[10] = '{3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h23};
    tbl[11] = '{3'd0, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 8'h2B};
    tbl[12] = '{3'd1, 8'h00, 8'h01, 1'b1, 1'b1, 8'h99, 8'hA8};
    tbl[13] = '{3'd1, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 8'h61};
    tbl[14] = '{3'd0, 8'h0F, 8'h00, 1'b0, 1'b1, 8'h15, 8'h28};
    tbl[15] = '{3'd5, 8'h55, 8'hFF, 1'b1, 1'b0, 8'hAB, 8'hA0};
    bus.alu_ctrl = 3'd0; bus.alu_AI = 8'h00; bus.alu_BI = 8'h00; bus.alu_carry = 1'b0; bus.alu_BCD = 1'b0;
    #1 reset = 1'b1;
    #1 check("reset_async", 8'h00, 8'h20);
    @(negedge clk);
    bus.alu_AI = 8'h50; bus.alu_BI = 8'h50;
    @(posedge clk); #1 check("reset_hold", 8'h00, 8'h20);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 16; i++)
      step($sformatf("vec%0d", i), tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].y, tbl[i].f);
    step("seq_add", 3'd0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 8'h20);
    step("seq_and", 3'd2, 8'hCC, 8'hAA, 1'b0, 1'b0, 8'h88, 8'hA0);
    step("seq_eor", 3'd4, 8'hCC, 8'hAA, 1'b0, 1'b0, 8'h66, 8'h20);
    step("seq_sr", 3'd6, 8'h02, 8'h00, 1'b0, 1'b0, 8'h01, 8'h20);
    step("seq_pass", 3'd7, 8'h00, 8'h55, 1'b0, 1'b0, 8'h00, 8'h22);
    for (int i = 0; i < 60; i++) begin
      logic [2:0] ctrl;
      logic [7:0] a, b;
      logic c, d;
      exp_t e;
      ctrl = 3'($urandom_range(0, 7));
      d = 1'($urandom);
      c = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      if (d && ctrl < 3'd2) begin
        a = to_bcd(int'($urandom_range(0, 99)));
        b = to_bcd(int'($urandom_range(0, 99)));
      end
      e = model(ctrl, a, b, c, d);
      step($sformatf("rand%0d_op%0d", i, ctrl), ctrl, a, b, c, d, e.y, e.f);
    end
    step("pre_reset", 3'd0, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 8'hE0);
    @(negedge clk);
    bus.alu_ctrl = 3'd7; bus.alu_AI = 8'h12;
    #2 reset = 1'b1;
    #1 check("mid_reset_async", 8'h00, 8'h20);
    @(posedge clk); #1 check("mid_reset_discard", 8'h00, 8'h20);
    @(negedge clk) reset = 1'b0;
    step("post_reset", 3'd7, 8'h34, 8'h00, 1'b0, 1'b0, 8'h34, 8'h20);
    step("post_reset2", 3'd0, 8'h01, 8'h01, 1'b1, 1'b1, 8'h03, 8'h28);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
